alu_pipe: RTL
=============

// Module: alu_pipe
// PURPOSE
//  Parametrised, pipelined successor of the 5-bit registered ALU. Width and latency are parameters;
//  op decode on a_en/b_en/a_op/b_op is unchanged. Adds a valid/ready handshake with backpressure,
//  overflow detection, optional saturation and an invalid-op counter. Sits between the op sequencer and result sink.
// PARAMETERS
//  WIDTH    5  operand width, signed two's complement (>=2)
//  LATENCY  1  pipeline stages from accept to out_valid (1..4)
//  SAT      0  1: clamp arithmetic results to the signed WIDTH range
//  CNT_W    8  err_cnt width (>=1)
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous active-low reset
//  ALU_en     in   1        global enable; low freezes the whole pipeline
//  in_valid   in   1        operand/op presented
//  in_ready   out  1        accept when in_valid & in_ready
//  A, B       in   WIDTH    signed operands
//  a_en,b_en  in   1        op-set select
//  a_op       in   3        op code when a_en=1, b_en=0
//  b_op       in   2        op code when b_en=1
//  out_valid  out  1        C/ovf/err valid
//  out_ready  in   1        sink accepts result
//  C          out  WIDTH+1  signed result
//  ovf        out  1        arithmetic result outside signed WIDTH range (pre-clamp)
//  err        out  1        result came from an invalid op
//  err_cnt    out  CNT_W    saturating count of accepted invalid ops
// BEHAVIOUR
//  Reset: all stage valids, out_valid, C, ovf, err, err_cnt = 0, asynchronously. A reset mid-stream drops in-flight ops.
//  Decode: a_en&!b_en: a_op 0 A+B, 1 A-B, 2 A^B, 3/4 A&B, 5 A|B, 6 A~^B, 7 invalid.
//   !a_en&b_en: b_op 0 ~(A&B), 1/2 A+B, 3 invalid.
//   a_en&b_en: b_op 0 A^B, 1 A~^B, 2 A-1, 3 B+2.
//   !a_en&!b_en: invalid.
//  Arithmetic: operands sign-extended to WIDTH+1 bits. The result is exact, so there is no wrap.
//   ovf=1 iff the result is < -2^(WIDTH-1) or > 2^(WIDTH-1)-1. Logic ops: ovf=0.
//  SAT=1: an arithmetic result with ovf=1 is clamped to -2^(WIDTH-1) or 2^(WIDTH-1)-1. ovf still reports 1.
//  Logic ops: computed on WIDTH bits, then sign-extended from bit WIDTH-1 into C[WIDTH].
//  Invalid op: C=0, ovf=0, err=1.
//  Pipeline: single global advance = ALU_en & (!out_valid | out_ready). in_ready = advance.
//   Every stage register (valid + payload) shifts only when advance=1. Bubbles are not collapsed.
//   Result computed in stage 1; stages 2..LATENCY are delay registers.
//   With out_ready=1 and ALU_en=1: throughput 1 op/cycle, out_valid exactly LATENCY cycles after accept.
//  Stall: out_valid=1 & out_ready=0 -> C/ovf/err held stable and in_ready=0. Order is always preserved.
//  ALU_en=0: no accept, no shift, outputs held. out_valid is unchanged and out_ready is ignored.
//  err_cnt: increments by 1 in the cycle an invalid op is accepted (not when it is output).
//   Holds at 2^CNT_W-1 and never wraps.
//  in_valid=0 with advance=1 inserts a bubble (stage valid=0). Payload of bubble stages is don't-care.
// TESTING
//  1 Reset: rst_n=0 with in_valid=1 -> in_ready follows ALU_en; out_valid=C=ovf=err=err_cnt=0.
//    Release, no ops -> outputs stay 0.
//  2 WIDTH=5,LATENCY=2,SAT=0: a_en=1,b_en=0,a_op=0,A=15,B=1 -> 2 cycles later out_valid=1, C=16, ovf=1.
//    Same with SAT=1 -> C=15, ovf=1.
//  3 a_en=b_en=1,b_op=2,A=-16 -> C=-17, ovf=1. b_op=3,B=3 -> C=5, ovf=0.
//    a_op=2,A=5'b10101,B=5'b00111 -> C=6'b110010.
//  4 Stream ops 1..6 back-to-back, out_ready=0 for 3 cycles after the first result -> in_ready=0 in those cycles,
//    C held, all 6 results delivered in order.
//  5 CNT_W=2: 5 invalid ops (a_en=b_en=0, then a_op=7, b_op=3 with !a_en&b_en) -> each C=0, err=1;
//    err_cnt 1,2,3,3,3.
//  6 ALU_en=0 for 2 cycles mid-stream -> no accept, outputs frozen.
//    rst_n pulse mid-stream -> out_valid=0 immediately (async); subsequent op returns after LATENCY.

Source files
------------

// File: rtl/alu_pipe.sv
// Pipelined signed ALU: stage 1 decodes and computes, later stages only delay.
// One global advance moves every stage at once, so order is always preserved.
module alu_pipe #(
  parameter int WIDTH   = 5,
  parameter int LATENCY = 1,
  parameter int SAT     = 0,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ALU_en,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               a_en,
  input  logic               b_en,
  input  logic [2:0]         a_op,
  input  logic [1:0]         b_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH:0]     C,
  output logic               ovf,
  output logic               err,
  output logic [CNT_W-1:0]   err_cnt
);

  typedef struct packed {
    logic [WIDTH:0] c;
    logic           ovf;
    logic           err;
  } res_t;

  logic [LATENCY:1]        vld_pipe;
  res_t [LATENCY:1]        pay_pipe;
  res_t                    res_d;
  logic                    advance;
  logic                    is_arith, is_inv;
  logic [WIDTH:0]          ax, bx, ares;
  logic [WIDTH-1:0]        lres;
  logic                    ovf_d;

  assign advance  = ALU_en & (~out_valid | out_ready);
  assign in_ready = advance;

  // Sign-extend so every arithmetic result fits exactly in WIDTH+1 bits.
  assign ax = {A[WIDTH-1], A};
  assign bx = {B[WIDTH-1], B};

  // Op decode: pick an arithmetic or logic result, or flag the op invalid.
  always_comb begin
    is_arith = 1'b0;
    is_inv   = 1'b0;
    ares     = '0;
    lres     = '0;
    case ({a_en, b_en})
      2'b10: case (a_op)
        3'd0:       begin is_arith = 1'b1; ares = ax + bx; end
        3'd1:       begin is_arith = 1'b1; ares = ax - bx; end
        3'd2:       lres = A ^ B;
        3'd3, 3'd4: lres = A & B;
        3'd5:       lres = A | B;
        3'd6:       lres = ~(A ^ B);
        default:    is_inv = 1'b1;
      endcase
      2'b01: case (b_op)
        2'd0:       lres = ~(A & B);
        2'd1, 2'd2: begin is_arith = 1'b1; ares = ax + bx; end
        default:    is_inv = 1'b1;
      endcase
      2'b11: case (b_op)
        2'd0:       lres = A ^ B;
        2'd1:       lres = ~(A ^ B);
        2'd2:       begin is_arith = 1'b1; ares = ax - (WIDTH+1)'(1); end
        default:    begin is_arith = 1'b1; ares = bx + (WIDTH+1)'(2); end
      endcase
      default: is_inv = 1'b1;
    endcase
  end

  // Out of range exactly when the top two result bits disagree.
  assign ovf_d = is_arith & (ares[WIDTH] ^ ares[WIDTH-1]);

  // Assemble the stage-1 payload, clamping overflowed arithmetic when enabled.
  always_comb begin
    res_d = '0;
    if (is_inv) begin
      res_d.err = 1'b1;
    end else if (is_arith) begin
      res_d.ovf = ovf_d;
      if ((SAT != 0) && ovf_d)
        res_d.c = ares[WIDTH] ? {2'b11, {(WIDTH-1){1'b0}}} : {2'b00, {(WIDTH-1){1'b1}}};
      else
        res_d.c = ares;
    end else begin
      res_d.c = {lres[WIDTH-1], lres};
    end
  end

  // Pipeline shift; bubbles carry a zero payload so idle outputs stay quiet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      pay_pipe <= '0;
    end else if (advance) begin
      vld_pipe[1] <= in_valid;
      pay_pipe[1] <= in_valid ? res_d : '0;
      for (int i = 2; i <= LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        pay_pipe[i] <= pay_pipe[i-1];
      end
    end
  end

  // Count invalid ops at accept time, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_cnt <= '0;
    else if (advance && in_valid && is_inv && (err_cnt != {CNT_W{1'b1}}))
      err_cnt <= err_cnt + CNT_W'(1);
  end

  assign out_valid = vld_pipe[LATENCY];
  assign C         = pay_pipe[LATENCY].c;
  assign ovf       = pay_pipe[LATENCY].ovf;
  assign err       = pay_pipe[LATENCY].err;

endmodule
